lsu_ctrl: RTL

//  Load/store controller between the core's memory stage and the word-wide data memory (DMEM).

---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu_ctrl_if.sv | 33 +++
 rtl/lsu_load_align.sv | 17 +
 rtl/lsu_ctrl.sv | 79 +++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, constants and the sub-word store merge for the load/store controller
package lsu_pkg;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD} size_t;
  typedef enum logic [2:0] {IDLE, LD_RD, LD_WAIT, ST_WR, RMW_RD, RMW_WR, RESP} state_t;
  localparam logic [1:0] MEM_WORD_SEL = 2'b10;
  function automatic logic [31:0] store_merge(
    input logic [31:0] word,
    input logic [31:0] wdata,
    input logic [1:0] addr,
    input size_t size
  );
    logic [31:0] m;
    logic [31:0] d;
    m = size == SZ_BYTE ? 32'h0000_00ff << {addr, 3'b000} :
        size == SZ_HALF ? 32'h0000_ffff << {addr[1], 4'b0000} : 32'hffff_ffff;
    d = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    return (word & ~m) | (d & m);
  endfunction
endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: core request/response and DMEM word-port signals of the load/store controller
interface lsu_ctrl_if #(
  parameter int ADDR_DEPTH = 14,
  parameter int ADDR_WIDTH = 32
);
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [1:0] req_size;
  logic req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [ADDR_WIDTH-1:0] req_wdata;
  logic rsp_valid;
  logic [ADDR_WIDTH-1:0] rsp_rdata;
  logic rsp_err;
  logic mem_rden;
  logic mem_wen;
  logic [1:0] mem_byte_sel;
  logic mem_sign;
  logic [ADDR_DEPTH-1:0] mem_addr;
  logic [ADDR_WIDTH-1:0] mem_wdata;
  logic [ADDR_WIDTH-1:0] mem_rdata;
  modport slave (
    input req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_rden, mem_wen, mem_byte_sel, mem_sign, mem_addr, mem_wdata
  );
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input req_ready, rsp_valid, rsp_rdata, rsp_err,
    input mem_rden, mem_wen, mem_byte_sel, mem_sign, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed byte/half lane of a memory word and sign/zero-extends it
module lsu_load_align
  import lsu_pkg::*;
(
  input logic [31:0] word,
  input logic [1:0] addr,
  input size_t size,
  input logic uns,
  output logic [31:0] data
);
  logic [31:0] sh_b;
  logic [31:0] sh_h;
  assign sh_b = word >> {addr, 3'b000};
  assign sh_h = word >> {addr[1], 4'b0000};
  assign data = size == SZ_BYTE ? {{24{~uns & sh_b[7]}}, sh_b[7:0]} :
                size == SZ_HALF ? {{16{~uns & sh_h[15]}}, sh_h[15:0]} : word;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: one-at-a-time byte/half/word load/store controller over a word-only DMEM
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_DEPTH = 14,
  parameter int ADDR_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  lsu_ctrl_if.slave bus
);
  state_t state;
  size_t size_q;
  size_t req_size;
  logic uns_q;
  logic err_q;
  logic acc_err;
  logic [ADDR_DEPTH+1:0] addr_q;
  logic [ADDR_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0] ld_data;
  assign req_size = size_t'(bus.req_size);
  assign acc_err = (req_size == SZ_HALF && bus.req_addr[0]) ||
                   (bus.req_size[1] && bus.req_addr[1:0] != 2'b00) ||
                   bus.req_addr[ADDR_WIDTH-1:ADDR_DEPTH+2] != '0;
  lsu_load_align u_align (
    .word(bus.mem_rdata),
    .addr(addr_q[1:0]),
    .size(size_q),
    .uns(uns_q),
    .data(ld_data)
  );
  // request latch, access sequencing and registered response data
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      size_q <= SZ_BYTE;
      uns_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          size_q <= req_size;
          uns_q <= bus.req_unsigned;
          addr_q <= bus.req_addr[ADDR_DEPTH+1:0];
          wdata_q <= bus.req_wdata;
          err_q <= acc_err;
          if (acc_err) rdata_q <= '0;
          state <= acc_err ? RESP : !bus.req_we ? LD_RD : bus.req_size[1] ? ST_WR : RMW_RD;
        end
        LD_RD: state <= LD_WAIT;
        LD_WAIT: begin
          rdata_q <= ld_data;
          state <= RESP;
        end
        ST_WR, RMW_WR: begin
          rdata_q <= '0;
          state <= RESP;
        end
        RMW_RD: state <= RMW_WR;
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.req_ready = ~rst & (state == IDLE);
  assign bus.rsp_valid = ~rst & (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err = err_q;
  assign bus.mem_rden = ~rst & (state == LD_RD || state == RMW_RD);
  assign bus.mem_wen = ~rst & (state == ST_WR || state == RMW_WR);
  assign bus.mem_byte_sel = MEM_WORD_SEL;
  assign bus.mem_sign = 1'b0;
  assign bus.mem_addr = state == IDLE ? '0 : addr_q[ADDR_DEPTH+1:2];
  assign bus.mem_wdata = state == ST_WR ? wdata_q :
                         state == RMW_WR ? store_merge(bus.mem_rdata, wdata_q, addr_q[1:0], size_q) : '0;
endmodule
